// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared widths, literal encoding and BCP state codes for the DPLL solver
package sat_pkg;

    localparam int NUM_VARIABLE   = 128;
    localparam int VARIABLE_INDEX = 6;
    localparam int VAR_PER_CLAUSE = 5;
    localparam int CLAUSE_INDEX   = 8;

    localparam int VAR_W = VARIABLE_INDEX + 1;
    localparam int CL_W  = CLAUSE_INDEX + 1;
    localparam int LIT_W = VARIABLE_INDEX + 3;

    typedef logic [VAR_W-1:0] var_idx_t;
    typedef logic [CL_W-1:0]  cl_addr_t;

    typedef struct packed {
        logic     valid;
        logic     polarity;
        var_idx_t var_idx;
    } lit_t;

    // Slot i occupies bits [i*LIT_W +: LIT_W] of the clause word.
    typedef lit_t [VAR_PER_CLAUSE-1:0] clause_t;

    typedef enum logic [2:0] {
        BCP_IDLE  = 3'd0,
        BCP_OCC   = 3'd1,
        BCP_RANGE = 3'd2,
        BCP_READ  = 3'd3,
        BCP_EVAL  = 3'd4,
        BCP_DONE  = 3'd5
    } bcp_state_t;

    localparam logic TYPE_IMPLIED = 1'b1;

endpackage

// File: rtl/bcp_engine_if.sv
// rtl/bcp_engine_if.sv - occurrence table, clause memory and imply-stack bus of the BCP engine
interface bcp_engine_if;
    import sat_pkg::*;

    logic     occ_req;
    var_idx_t occ_var;
    cl_addr_t occ_start;
    cl_addr_t occ_end;

    logic     cl_rd_en;
    cl_addr_t cl_addr;
    clause_t  cl_lits;

    logic     push;
    var_idx_t push_var;
    logic     push_val;
    logic     push_type;
    logic     full;

    modport master (
        output occ_req, occ_var,
        input  occ_start, occ_end,
        output cl_rd_en, cl_addr,
        input  cl_lits,
        output push, push_var, push_val, push_type,
        input  full
    );

    modport slave (
        input  occ_req, occ_var,
        output occ_start, occ_end,
        input  cl_rd_en, cl_addr,
        output cl_lits,
        input  push, push_var, push_val, push_type,
        output full
    );

endinterface

// File: rtl/bcp_clause_eval.sv
// rtl/bcp_clause_eval.sv - combinational classification of one clause against the variable state table
module bcp_clause_eval
    import sat_pkg::*;
(
    input  clause_t                 lits,
    input  logic [NUM_VARIABLE-1:0] assigned_vec,
    input  logic [NUM_VARIABLE-1:0] value_vec,
    output logic                    satisfied,
    output logic                    conflict,
    output logic                    unit,
    output var_idx_t                unit_var,
    output logic                    unit_val
);

    logic       any_true;
    logic [2:0] n_unassigned;

    always_comb begin
        any_true     = 1'b0;
        n_unassigned = 3'd0;
        unit_var     = '0;
        unit_val     = 1'b0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (lits[i].valid) begin
                if (assigned_vec[lits[i].var_idx]) begin
                    if (value_vec[lits[i].var_idx] == lits[i].polarity)
                        any_true = 1'b1;
                end else begin
                    n_unassigned = n_unassigned + 3'd1;
                    unit_var     = lits[i].var_idx;
                    unit_val     = lits[i].polarity;
                end
            end
        end
    end

    assign satisfied = any_true;
    assign conflict  = !any_true && (n_unassigned == 3'd0);
    assign unit      = !any_true && (n_unassigned == 3'd1);

endmodule

// File: rtl/bcp_engine.sv
// rtl/bcp_engine.sv - walks one variable's occurrence list, pushing implications and flagging conflicts
module bcp_engine
    import sat_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  var_idx_t                prop_var,
    input  logic                    prop_val,
    output logic                    busy,
    output logic                    done,
    output logic                    conflict,
    input  logic [NUM_VARIABLE-1:0] assigned_vec,
    input  logic [NUM_VARIABLE-1:0] value_vec,
    bcp_engine_if.master            bus
);

    localparam logic [2:0] ST_IDLE  = BCP_IDLE;
    localparam logic [2:0] ST_OCC   = BCP_OCC;
    localparam logic [2:0] ST_RANGE = BCP_RANGE;
    localparam logic [2:0] ST_READ  = BCP_READ;
    localparam logic [2:0] ST_EVAL  = BCP_EVAL;
    localparam logic [2:0] ST_DONE  = BCP_DONE;

    logic [2:0] state;
    var_idx_t   var_q;
    logic       val_q;
    cl_addr_t   ptr;
    cl_addr_t   range_end;
    logic       conflict_q;

    logic       ev_satisfied;
    logic       ev_conflict;
    logic       ev_unit;
    var_idx_t   ev_var;
    logic       ev_val;
    logic       clause_done;

    bcp_clause_eval u_eval (
        .lits         (bus.cl_lits),
        .assigned_vec (assigned_vec),
        .value_vec    (value_vec),
        .satisfied    (ev_satisfied),
        .conflict     (ev_conflict),
        .unit         (ev_unit),
        .unit_var     (ev_var),
        .unit_val     (ev_val)
    );

    // A unit clause cannot retire until the stack accepts its push.
    assign clause_done = ev_satisfied || !ev_unit || !bus.full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            var_q      <= '0;
            val_q      <= 1'b0;
            ptr        <= '0;
            range_end  <= '0;
            conflict_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        var_q      <= prop_var;
                        val_q      <= prop_val;
                        conflict_q <= 1'b0;
                        state      <= ST_OCC;
                    end
                end
                ST_OCC:   state <= ST_RANGE;
                ST_RANGE: begin
                    ptr       <= bus.occ_start;
                    range_end <= bus.occ_end;
                    state     <= (bus.occ_start > bus.occ_end) ? ST_DONE : ST_READ;
                end
                ST_READ:  state <= ST_EVAL;
                ST_EVAL: begin
                    if (ev_conflict) begin
                        conflict_q <= 1'b1;
                        state      <= ST_DONE;
                    end else if (clause_done) begin
                        // Compare before increment so a range ending at the top address never wraps.
                        if (ptr == range_end) begin
                            state <= ST_DONE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign conflict      = conflict_q;

    assign bus.occ_req   = (state == ST_OCC);
    assign bus.occ_var   = var_q;
    assign bus.cl_rd_en  = (state == ST_READ);
    assign bus.cl_addr   = ptr;

    assign bus.push      = (state == ST_EVAL) && ev_unit && !bus.full && !reset;
    assign bus.push_var  = bus.push ? ev_var : '0;
    assign bus.push_val  = bus.push ? ev_val : 1'b0;
    assign bus.push_type = TYPE_IMPLIED;

endmodule

// File: tb/tb_bcp_engine.sv
// tb/tb_bcp_engine.sv - directed self-checking bench for bcp_engine
module tb_bcp_engine;
    import sat_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    start;
    var_idx_t                prop_var;
    logic                    prop_val;
    logic                    busy;
    logic                    done;
    logic                    conflict;
    logic [NUM_VARIABLE-1:0] assigned_vec;
    logic [NUM_VARIABLE-1:0] value_vec;

    int compared   = 0;
    int mismatched = 0;

    bcp_engine_if bus ();

    bcp_engine dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .prop_var     (prop_var),
        .prop_val     (prop_val),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .assigned_vec (assigned_vec),
        .value_vec    (value_vec),
        .bus          (bus.master)
    );

    always #5 clock = ~clock;

    clause_t        clause_mem [0:511];
    logic [8:0]     push_log [$];
    logic [8:0]     rd_log [$];
    int             bad_push_full = 0;

    always @(posedge clock) begin
        if (bus.cl_rd_en) bus.cl_lits <= clause_mem[bus.cl_addr];
        if (bus.push) push_log.push_back({bus.push_var, bus.push_val, bus.push_type});
        if (bus.cl_rd_en) rd_log.push_back(bus.cl_addr);
        if (bus.push && bus.full) bad_push_full++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic lit_t mk_lit(input logic pol, input int v);
        lit_t l;
        l.valid    = 1'b1;
        l.polarity = pol;
        l.var_idx  = var_idx_t'(v);
        return l;
    endfunction

    // Cycle 0 is the cycle start is sampled; n counts clock edges after it.
    task automatic run_bcp(input int v, input logic pv, input int full_drop,
                           output int done_cyc, output int push_cyc, output int occ_seen);
        push_log.delete();
        rd_log.delete();
        @(posedge clock);
        @(negedge clock);
        prop_var = var_idx_t'(v);
        prop_val = pv;
        full_set(full_drop > 0);
        start    = 1'b1;
        done_cyc = -1;
        push_cyc = -1;
        occ_seen = -1;
        for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            full_set(n < full_drop);
            #1;
            if (bus.occ_req) occ_seen = int'(bus.occ_var);
            if (bus.push && push_cyc < 0) push_cyc = n;
            if (done) done_cyc = n;
        end
        full_set(1'b0);
    endtask

    task automatic full_set(input logic f);
        bus.full = f;
    endtask

    int         dc, pc, ov;
    logic [8:0] exp_push;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        prop_var     = '0;
        prop_val     = 1'b0;
        bus.full     = 1'b0;
        bus.occ_start = '0;
        bus.occ_end   = '0;
        bus.cl_lits   = '0;
        for (int i = 0; i < 512; i++) clause_mem[i] = '0;
        // x3 = 0 and x5 = 0 assigned; everything else unassigned.
        assigned_vec = '0;
        value_vec    = '0;
        assigned_vec[3] = 1'b1;
        assigned_vec[5] = 1'b1;

        clause_mem[10][0] = mk_lit(1'b1, 3);
        clause_mem[10][1] = mk_lit(1'b0, 7);
        clause_mem[0][0]  = mk_lit(1'b0, 3);
        clause_mem[1][0]  = mk_lit(1'b1, 3);
        clause_mem[1][1]  = mk_lit(1'b1, 5);
        clause_mem[2][0]  = mk_lit(1'b1, 7);
        clause_mem[3][0]  = mk_lit(1'b1, 9);
        clause_mem[510][0] = mk_lit(1'b0, 3);
        clause_mem[511][0] = mk_lit(1'b0, 5);
        clause_mem[511][3] = mk_lit(1'b1, 20);

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conflict", conflict, 0);
        check("rst_occ_req", bus.occ_req, 0);
        check("rst_cl_rd_en", bus.cl_rd_en, 0);
        check("rst_push", bus.push, 0);
        check("rst_push_type", bus.push_type, 1);
        check("rst_cl_addr", bus.cl_addr, 0);
        check("rst_occ_var", bus.occ_var, 0);
        @(negedge clock);
        reset = 1'b0;

        // Empty occurrence list
        bus.occ_start = 9'd5;
        bus.occ_end   = 9'd4;
        run_bcp(42, 1'b1, 0, dc, pc, ov);
        check("empty_done_cycle", dc, 3);
        check("empty_conflict", conflict, 0);
        check("empty_pushes", push_log.size(), 0);
        check("empty_reads", rd_log.size(), 0);
        check("empty_occ_var", ov, 42);

        // Single unit clause implies x7 = 0
        bus.occ_start = 9'd10;
        bus.occ_end   = 9'd10;
        run_bcp(3, 1'b0, 0, dc, pc, ov);
        exp_push = {7'd7, 1'b0, 1'b1};
        check("unit_done_cycle", dc, 5);
        check("unit_push_count", push_log.size(), 1);
        check("unit_push_entry", push_log[0], exp_push);
        check("unit_push_cycle", pc, 4);
        check("unit_conflict", conflict, 0);
        check("unit_reads", rd_log.size(), 1);

        // Clause 1 is fully false: scan stops there
        bus.occ_start = 9'd0;
        bus.occ_end   = 9'd3;
        run_bcp(5, 1'b0, 0, dc, pc, ov);
        check("confl_done_cycle", dc, 7);
        check("confl_flag", conflict, 1);
        check("confl_reads", rd_log.size(), 2);
        check("confl_last_read", rd_log[1], 1);
        check("confl_pushes", push_log.size(), 0);
        repeat (3) @(posedge clock);
        #1;
        check("confl_held", conflict, 1);

        // Start held through the whole run: ignored while busy and in the done cycle
        bus.occ_start = 9'd5;
        bus.occ_end   = 9'd4;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        check("restart_clears_conflict", conflict, 0);
        repeat (2) @(posedge clock);
        #1;
        check("held_start_done", done, 1);
        @(posedge clock);
        #1;
        check("held_start_idle", busy, 0);
        start = 1'b0;

        // Stack full for four EVAL cycles
        bus.occ_start = 9'd10;
        bus.occ_end   = 9'd10;
        bad_push_full = 0;
        run_bcp(3, 1'b0, 8, dc, pc, ov);
        check("bp_done_cycle", dc, 9);
        check("bp_push_cycle", pc, 8);
        check("bp_push_while_full", bad_push_full, 0);
        check("bp_push_count", push_log.size(), 1);

        // Range touching the top clause address
        bus.occ_start = 9'd510;
        bus.occ_end   = 9'd511;
        run_bcp(3, 1'b0, 0, dc, pc, ov);
        check("top_done_cycle", dc, 7);
        check("top_reads", rd_log.size(), 2);
        check("top_read0", rd_log[0], 510);
        check("top_read1", rd_log[1], 511);
        check("top_pushes", push_log.size(), 0);
        @(posedge clock);
        #1;
        check("top_idle_after", busy, 0);

        // Reset while stalled in EVAL, released in the same cycle as full
        bus.occ_start = 9'd10;
        bus.occ_end   = 9'd10;
        push_log.delete();
        @(negedge clock);
        bus.full = 1'b1;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rstmid_in_eval_busy", busy, 1);
        reset    = 1'b1;
        bus.full = 1'b0;
        #1;
        check("rstmid_push_gated", bus.push, 0);
        @(posedge clock);
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_pushes", push_log.size(), 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
